// File: rtl/add_operand_feeder_if.sv
// Operand/result bundle between the operand feeder, its stream neighbours and the delayed adder.
// The slave modport is the feeder; the master modport is the surrounding environment.
interface add_operand_feeder_if #(
  parameter int unsigned numberOfBits = 8,
  parameter int unsigned counterWidth = 4
);
  logic [numberOfBits-1:0] inData;
  logic                    inValid;
  logic                    inReady;
  logic [numberOfBits-1:0] leftInput;
  logic [numberOfBits-1:0] rightInput;
  logic [numberOfBits-1:0] sumIn;
  logic [numberOfBits-1:0] outData;
  logic                    outValid;
  logic                    outReady;
  logic                    busy;
  logic [counterWidth-1:0] pairCount;

  modport slave (
    input  inData, inValid, sumIn, outReady,
    output inReady, leftInput, rightInput, outData, outValid, busy, pairCount
  );

  modport master (
    output inData, inValid, sumIn, outReady,
    input  inReady, leftInput, rightInput, outData, outValid, busy, pairCount
  );
endinterface

// File: rtl/add_operand_feeder.sv
// Pairs a byte stream into adder operands, holds them stable, waits a settle time,
// then captures the adder result and offers it on a valid/ready output.
module add_operand_feeder #(
  parameter int unsigned numberOfBits = 8,
  parameter int unsigned settleCycles = 2,
  parameter int unsigned counterWidth = 4
) (
  input  logic                 clock,
  input  logic                 resetN,
  add_operand_feeder_if.slave  bus
);

  // A settle time of zero still needs one edge before the capture.
  localparam int unsigned settleEdges = (settleCycles == 0) ? 1 : settleCycles;
  localparam int unsigned settleLast  = settleEdges - 1;
  localparam int unsigned settleWidth = (settleLast > 0) ? $clog2(settleLast + 1) : 1;

  typedef enum logic [1:0] {
    WAIT_LEFT,
    WAIT_RIGHT,
    SETTLE,
    PRESENT
  } stateType;

  stateType               state;
  logic [settleWidth-1:0] settleCounter;
  logic                   inTransfer;
  logic                   outTransfer;

  assign bus.inReady = (state == WAIT_LEFT) || (state == WAIT_RIGHT);
  assign bus.busy    = (state != WAIT_LEFT);
  assign inTransfer  = bus.inValid && bus.inReady;
  assign outTransfer = bus.outValid && bus.outReady;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state          <= WAIT_LEFT;
      bus.leftInput  <= '0;
      bus.rightInput <= '0;
      bus.outData    <= '0;
      bus.outValid   <= 1'b0;
      bus.pairCount  <= '0;
      settleCounter  <= '0;
    end else begin
      case (state)
        WAIT_LEFT: begin
          if (inTransfer) begin
            bus.leftInput <= bus.inData;
            state         <= WAIT_RIGHT;
          end
        end
        WAIT_RIGHT: begin
          if (inTransfer) begin
            bus.rightInput <= bus.inData;
            settleCounter  <= settleWidth'(settleLast);
            state          <= SETTLE;
          end
        end
        SETTLE: begin
          if (settleCounter != '0) begin
            settleCounter <= settleCounter - settleWidth'(1);
          end else begin
            bus.outData  <= bus.sumIn;
            bus.outValid <= 1'b1;
            state        <= PRESENT;
          end
        end
        PRESENT: begin
          // Operands stay on the adder until the result has been taken.
          if (outTransfer) begin
            bus.outValid  <= 1'b0;
            bus.pairCount <= bus.pairCount + counterWidth'(1);
            state         <= WAIT_LEFT;
          end
        end
        default: state <= WAIT_LEFT;
      endcase
    end
  end

endmodule

// File: tb/tb_add_operand_feeder.sv
// Directed and randomized checks of add_operand_feeder against a delayed-adder model
// and an arithmetic reference for sums, latency, pair counting and reset behaviour.
module tb_add_operand_feeder;
  localparam int unsigned NB = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned SC = 2;

  logic        clock = 1'b0;
  logic        resetN;
  int unsigned tests = 0;
  int unsigned failures = 0;
  int unsigned cycle = 0;
  logic [NB-1:0] adderSettled;

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  add_operand_feeder_if #(.numberOfBits(NB), .counterWidth(CW)) bus ();

  add_operand_feeder #(
    .numberOfBits(NB),
    .settleCycles(SC),
    .counterWidth(CW)
  ) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  // Adder with a 7 ns propagation delay, below the two-clock settle window.
  always begin
    @(bus.leftInput or bus.rightInput);
    adderSettled = NB'(bus.leftInput + bus.rightInput);
    #7;
    bus.sumIn = adderSettled;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [NB-1:0] refSum(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int unsigned total;
    total = (int'(a) + int'(b)) % 256;
    return NB'(total);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendOperand(input logic [NB-1:0] d);
    int n;
    n = 0;
    bus.inData  = d;
    bus.inValid = 1'b1;
    while (!bus.inReady && n < 50) begin
      tick();
      n++;
    end
    check("acceptReady", 32'(bus.inReady), 32'd1);
    tick();
    bus.inValid = 1'b0;
  endtask

  task automatic waitOutValid();
    int n;
    n = 0;
    while (!bus.outValid && n < 50) begin
      tick();
      n++;
    end
    check("outValidWait", 32'(bus.outValid), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, ".left"},     32'(bus.leftInput),  32'd0);
    check({tag, ".right"},    32'(bus.rightInput), 32'd0);
    check({tag, ".outData"},  32'(bus.outData),    32'd0);
    check({tag, ".outValid"}, 32'(bus.outValid),   32'd0);
    check({tag, ".pairs"},    32'(bus.pairCount),  32'd0);
    check({tag, ".inReady"},  32'(bus.inReady),    32'd1);
    check({tag, ".busy"},     32'(bus.busy),       32'd0);
  endtask

  initial begin
    int unsigned expPairs;
    int unsigned acceptEdge;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] heldData;
    logic [NB-1:0] ops [32];
    int unsigned idx;
    int unsigned got;
    int unsigned lastCapture;
    logic haveCapture;
    logic sawReady;
    logic sawValid;
    logic [NB-1:0] sawData;

    bus.inData   = '0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    bus.sumIn    = '0;
    resetN       = 1'b0;
    expPairs     = 0;
    #12 resetN = 1'b1;
    tick();

    // Asynchronous reset asserted between edges while a pair is partly loaded
    sendOperand(8'h77);
    check("t1.busyBefore", 32'(bus.busy), 32'd1);
    #2 resetN = 1'b0;
    #1 checkResetValues("t1");
    #3 resetN = 1'b1;
    tick();

    // 0x12 + 0x34 with exact capture latency
    sendOperand(8'h12);
    check("t2.left", 32'(bus.leftInput), 32'h12);
    check("t2.busyRight", 32'(bus.busy), 32'd1);
    sendOperand(8'h34);
    acceptEdge = cycle;
    check("t2.right", 32'(bus.rightInput), 32'h34);
    check("t2.inReadySettle", 32'(bus.inReady), 32'd0);
    tick();
    check("t2.notYetValid", 32'(bus.outValid), 32'd0);
    tick();
    check("t2.outValid", 32'(bus.outValid), 32'd1);
    check("t2.latency", 32'(cycle - acceptEdge), 32'(SC));
    check("t2.sum", 32'(bus.outData), 32'(refSum(8'h12, 8'h34)));
    bus.outReady = 1'b1;
    tick();
    expPairs++;
    bus.outReady = 1'b0;
    check("t2.pairs", 32'(bus.pairCount), 32'(expPairs % 16));
    check("t2.validDrop", 32'(bus.outValid), 32'd0);
    check("t2.idle", 32'(bus.busy), 32'd0);

    // Wrapping sum, pair counter step on accept
    sendOperand(8'hF0);
    sendOperand(8'h20);
    waitOutValid();
    check("t3.sumWrap", 32'(bus.outData), 32'h10);
    check("t3.pairsHeld", 32'(bus.pairCount), 32'(expPairs % 16));
    bus.outReady = 1'b1;
    tick();
    expPairs++;
    bus.outReady = 1'b0;
    check("t3.pairs", 32'(bus.pairCount), 32'(expPairs % 16));

    // Output stall with a pushy source
    a = NB'($urandom_range(0, 255));
    b = NB'($urandom_range(0, 255));
    sendOperand(a);
    sendOperand(b);
    waitOutValid();
    heldData = bus.outData;
    check("t4.sum", 32'(heldData), 32'(refSum(a, b)));
    bus.inValid = 1'b1;
    bus.inData  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4.stableData", 32'(bus.outData),    32'(heldData));
      check("t4.stableValid", 32'(bus.outValid),  32'd1);
      check("t4.inReady",    32'(bus.inReady),    32'd0);
      check("t4.left",       32'(bus.leftInput),  32'(a));
      check("t4.right",      32'(bus.rightInput), 32'(b));
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    tick();
    expPairs++;
    bus.outReady = 1'b0;
    check("t4.validDrop", 32'(bus.outValid), 32'd0);
    check("t4.idle", 32'(bus.busy), 32'd0);
    check("t4.pairs", 32'(bus.pairCount), 32'(expPairs % 16));
    tick();
    check("t4.singleTransfer", 32'(bus.pairCount), 32'(expPairs % 16));

    // Reset during the settle window discards the pair
    sendOperand(8'h55);
    sendOperand(8'h66);
    tick();
    #2 resetN = 1'b0;
    #1 checkResetValues("t5");
    #3 resetN = 1'b1;
    expPairs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5.noSpurious", 32'(bus.outValid), 32'd0);
    end
    sendOperand(8'h01);
    sendOperand(8'h02);
    waitOutValid();
    check("t5.sum", 32'(bus.outData), 32'h03);
    bus.outReady = 1'b1;
    tick();
    expPairs++;
    bus.outReady = 1'b0;
    check("t5.pairs", 32'(bus.pairCount), 32'(expPairs % 16));

    // Sixteen back-to-back random pairs, counter wrap and throughput
    #2 resetN = 1'b0;
    #2 resetN = 1'b1;
    expPairs = 0;
    for (int i = 0; i < 32; i++) ops[i] = NB'($urandom_range(0, 255));
    tick();
    idx = 0;
    got = 0;
    lastCapture = 0;
    haveCapture = 1'b0;
    bus.outReady = 1'b1;
    for (int c = 0; c < 200 && got < 16; c++) begin
      bus.inValid = (idx < 32);
      bus.inData  = (idx < 32) ? ops[idx[4:0]] : '0;
      sawReady = bus.inReady;
      sawValid = bus.outValid;
      sawData  = bus.outData;
      tick();
      if (sawReady && idx < 32) idx++;
      if (sawValid) begin
        check("t6.sum", 32'(sawData), 32'(refSum(ops[2*got], ops[2*got+1])));
        got++;
        expPairs++;
        check("t6.pairs", 32'(bus.pairCount), 32'(expPairs % 16));
      end
      if (bus.outValid && !sawValid) begin
        if (haveCapture) check("t6.spacing", 32'(cycle - lastCapture), 32'd5);
        lastCapture = cycle;
        haveCapture = 1'b1;
      end
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    check("t6.count", 32'(got), 32'd16);
    check("t6.pairWrap", 32'(bus.pairCount), 32'd0);
    check("t6.consumed", 32'(idx), 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
